// File: rtl/cpu_sys_ctrl_pkg.sv
// rtl/cpu_sys_ctrl_pkg.sv - shared state encoding, default widths and sizing helpers
package cpu_sys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_IW = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Select/counter width that never collapses to zero bits
  function automatic int selw(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_dbg_mux.sv
// rtl/cpu_dbg_mux.sv - registered NREG x DW debug register selector
module cpu_dbg_mux
  import cpu_sys_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = DEF_DW,
  parameter int SW   = selw(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREG*DW-1:0]   regs_i,
  input  logic [SW-1:0]        sel_i,
  output logic [DW-1:0]        out_o
);

  logic [DW-1:0] out_d;
  logic [DW-1:0] out_q;

  // Unmatched select codes (NREG not a power of two) read as zero
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_i == SW'(i)) out_d = regs_i[i*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end

  assign out_o = out_q;

endmodule

// File: rtl/cpu_sys_ctrl.sv
// rtl/cpu_sys_ctrl.sv - fetch/exec/mem/commit sequencer with run/step/halt, counters and debug readout
module cpu_sys_ctrl
  import cpu_sys_ctrl_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int IW          = DEF_IW,
  parameter int NREG        = 8,
  parameter int IMEM_LAT    = 0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CW          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt_req,
  input  logic                    err_clr,
  input  logic [AW-1:0]           core_pc,
  input  logic [AW-1:0]           core_addr,
  input  logic [DW-1:0]           core_wdata,
  input  logic                    core_mw,
  input  logic                    core_mr,
  output logic                    core_en,
  output logic [IW-1:0]           core_ir,
  output logic [DW-1:0]           core_rdata,
  output logic [AW-1:0]           im_addr,
  input  logic [IW-1:0]           im_data,
  output logic [AW-1:0]           dm_addr,
  output logic [DW-1:0]           dm_wdata,
  output logic                    dm_we,
  output logic                    dm_re,
  input  logic [DW-1:0]           dm_rdata,
  input  logic                    dm_ack,
  input  logic [NREG*DW-1:0]      dbg_regs,
  input  logic [selw(NREG)-1:0]   dbg_sel,
  output logic [DW-1:0]           dbg_out,
  output logic [2:0]              state,
  output logic                    bus_err,
  output logic [CW-1:0]           cycle_cnt,
  output logic [CW-1:0]           instr_cnt
);

  localparam int WMAX = (IMEM_LAT > MEM_TIMEOUT) ? IMEM_LAT : MEM_TIMEOUT;
  localparam int WCW  = selw(WMAX + 1);

  state_e         state_q;
  logic [WCW-1:0] wait_q;
  logic           one_shot_q;
  logic [IW-1:0]  core_ir_q;
  logic [DW-1:0]  core_rdata_q;
  logic [AW-1:0]  dm_addr_q;
  logic [DW-1:0]  dm_wdata_q;
  logic           dm_we_q;
  logic           dm_re_q;
  logic           bus_err_q;
  logic [CW-1:0]  cycle_q;
  logic [CW-1:0]  instr_q;

  logic mem_req;
  logic boundary;

  // core_en depends on the CPU's same-cycle mw/mr, so the boundary is decoded combinationally
  assign mem_req  = core_mw | core_mr;
  assign boundary = ((state_q == ST_EXEC) && !mem_req) || (state_q == ST_COMMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      one_shot_q   <= 1'b0;
      core_ir_q    <= '0;
      core_rdata_q <= '0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_we_q      <= 1'b0;
      dm_re_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      cycle_q      <= '0;
      instr_q      <= '0;
    end else begin
      if (state_q != ST_IDLE) cycle_q <= cycle_q + CW'(1);
      if (err_clr) bus_err_q <= 1'b0;

      if (boundary) begin
        instr_q <= instr_q + CW'(1);
        if (one_shot_q || halt_req || !run) begin
          state_q    <= ST_IDLE;
          one_shot_q <= 1'b0;
        end else begin
          state_q <= ST_FETCH;
          wait_q  <= '0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (!bus_err_q) begin
            if (run) begin
              state_q <= ST_FETCH;
              wait_q  <= '0;
            end else if (step) begin
              one_shot_q <= 1'b1;
              state_q    <= ST_FETCH;
              wait_q     <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (wait_q == WCW'(IMEM_LAT)) begin
            core_ir_q <= im_data;
            wait_q    <= '0;
            state_q   <= ST_EXEC;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        ST_EXEC: begin
          if (mem_req) begin
            dm_addr_q  <= core_addr;
            dm_wdata_q <= core_wdata;
            dm_we_q    <= core_mw;
            dm_re_q    <= core_mr & ~core_mw;
            wait_q     <= '0;
            state_q    <= ST_MEM;
          end
        end
        ST_MEM: begin
          // An ack arriving on the timeout cycle still completes the access
          if (dm_ack) begin
            dm_we_q <= 1'b0;
            dm_re_q <= 1'b0;
            if (dm_re_q) core_rdata_q <= dm_rdata;
            state_q <= ST_COMMIT;
          end else if (wait_q == WCW'(MEM_TIMEOUT)) begin
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            bus_err_q  <= 1'b1;
            one_shot_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        ST_COMMIT: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  cpu_dbg_mux #(
    .NREG (NREG),
    .DW   (DW),
    .SW   (selw(NREG))
  ) u_dbg_mux (
    .clk_i  (clk),
    .rst_ni (reset),
    .regs_i (dbg_regs),
    .sel_i  (dbg_sel),
    .out_o  (dbg_out)
  );

  assign core_en    = boundary;
  assign core_ir    = core_ir_q;
  assign core_rdata = core_rdata_q;
  assign im_addr    = core_pc;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_we      = dm_we_q;
  assign dm_re      = dm_re_q;
  assign state      = state_q;
  assign bus_err    = bus_err_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;

endmodule
